// File: rtl/pdm_mic_emulator_pkg.sv
// Shared constants and helpers for the PDM microphone emulator.
// Pure definitions; no timing or flow control of its own.
package pdm_mic_emulator_pkg;

  localparam int SAMPLE_W_DEF = 16;
  localparam int SYNC_STAGES  = 2;

  // Two's complement to offset binary: flip the sign bit of a w-bit value (w <= 32).
  function automatic logic [31:0] to_offset_bin(input logic [31:0] s, input int w);
    return s ^ (32'h1 << (w - 1));
  endfunction

endpackage

// File: rtl/pdm_sample_fifo.sv
// Synchronous FIFO with push, pop, level, full and empty.
// Read data is combinational from the head; full push and empty pop are ignored.
module pdm_sample_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [W-1:0]     din_i,
  input  logic             pop_i,
  output logic [W-1:0]     dout_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_comb begin
    level_d = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  // Storage needs no reset; only entries below level are ever read.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/pdm_mic_emulator.sv
// PCM-to-PDM microphone emulator: FIFO-buffered samples, first-order delta-sigma output.
// pdm_data moves 3 clk after the selected mic_clk edge; pcm_ready drops while the FIFO is full.
module pdm_mic_emulator
  import pdm_mic_emulator_pkg::*;
#(
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mic_clk,
  input  logic                        lr_sel,
  input  logic                        en,
  input  logic [7:0]                  osr,
  input  logic [SAMPLE_W-1:0]         pcm_in,
  input  logic                        pcm_valid,
  output logic                        pcm_ready,
  output logic                        pdm_data,
  output logic                        underflow,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   rise, fall, active;
  logic [SAMPLE_W-1:0]    acc_q, acc_d, cur_q, cur_d, sample_sel, x;
  logic [SAMPLE_W:0]      sum;
  logic [31:0]            x_wide;
  logic [7:0]             cnt_q, cnt_d;
  logic                   pdm_q, pdm_d, uf_q, uf_d;
  logic                   pop, fifo_full, fifo_empty;
  logic [SAMPLE_W-1:0]    fifo_dout;

  pdm_sample_fifo #(.W(SAMPLE_W), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (pcm_valid && pcm_ready),
    .din_i   (pcm_in),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .level_o (level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign pcm_ready = !fifo_full;
  assign pdm_data  = pdm_q;
  assign underflow = uf_q;

  assign rise   = sync_q[SYNC_STAGES-1] && !edge_q;
  assign fall   = !sync_q[SYNC_STAGES-1] && edge_q;
  assign active = lr_sel ? rise : fall;

  // The head is popped at counter zero and modulated in the same step.
  assign sample_sel = (cnt_q == 8'd0 && !fifo_empty) ? fifo_dout : cur_q;
  assign x_wide     = to_offset_bin(32'(sample_sel), SAMPLE_W);
  assign x          = x_wide[SAMPLE_W-1:0];
  assign sum        = {1'b0, acc_q} + {1'b0, x};

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    cur_d = cur_q;
    pdm_d = pdm_q;
    uf_d  = 1'b0;
    pop   = 1'b0;
    if (!en) begin
      acc_d = '0;
      cnt_d = '0;
      pdm_d = 1'b0;
    end else if (active) begin
      if (cnt_q == 8'd0) begin
        if (fifo_empty) begin
          uf_d = 1'b1;
        end else begin
          pop   = 1'b1;
          cur_d = fifo_dout;
        end
      end
      // A counter already past a lowered osr runs on to the 8-bit wrap.
      cnt_d = (cnt_q == osr) ? 8'd0 : cnt_q + 8'd1;
      acc_d = sum[SAMPLE_W-1:0];
      pdm_d = sum[SAMPLE_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
      acc_q  <= '0;
      cnt_q  <= '0;
      cur_q  <= '0;
      pdm_q  <= 1'b0;
      uf_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], mic_clk};
      edge_q <= sync_q[SYNC_STAGES-1];
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      cur_q  <= cur_d;
      pdm_q  <= pdm_d;
      uf_q   <= uf_d;
    end
  end

endmodule

// File: tb/tb_pdm_mic_emulator.sv
// Self-checking bench for pdm_mic_emulator: table of modulation cases plus
// hand-written reset, backpressure and enable sequences.
module tb_pdm_mic_emulator;

  localparam int SW   = 16;
  localparam int LW   = 3;
  localparam int HALF = 10;

  logic          clk = 1'b0, rst_n = 1'b1, mic_clk = 1'b0, lr_sel = 1'b1, en = 1'b0;
  logic [7:0]    osr = 8'd0;
  logic [SW-1:0] pcm_in = '0;
  logic          pcm_valid = 1'b0;
  logic          pcm_ready, pdm_data, underflow;
  logic [LW-1:0] level;

  pdm_mic_emulator #(.SAMPLE_W(SW), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mic_clk   (mic_clk),
    .lr_sel    (lr_sel),
    .en        (en),
    .osr       (osr),
    .pcm_in    (pcm_in),
    .pcm_valid (pcm_valid),
    .pcm_ready (pcm_ready),
    .pdm_data  (pdm_data),
    .underflow (underflow),
    .level     (level)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [SW-1:0] s0, s1;
    int            nsamp;
    logic [7:0]    osr;
    bit            lr;
    int            w1, ones1, w2, ones2, ufc, uff;
  } vec_t;

  typedef struct {
    int ones1, ones2, ufc, uff;
  } exp_t;

  vec_t vecs[7];
  exp_t sbq[$];

  int   n_cmp = 0, n_bad = 0;
  int   edge_idx = 0, uf_cnt = 0, first_uf = 0, n_viol = 0;
  logic pdm_prev = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pdm may only move on the 3rd clk after the active mic_clk transition.
  task automatic watch(input bit active_half);
    for (int k = 1; k <= HALF; k++) begin
      @(negedge clk);
      if (underflow) begin
        uf_cnt++;
        if (first_uf == 0) first_uf = edge_idx;
      end
      if (pdm_data !== pdm_prev) begin
        if (!(active_half && k == 3)) n_viol++;
        pdm_prev = pdm_data;
      end
    end
  endtask

  task automatic mic_cycle(output bit b);
    mic_clk = lr_sel ? 1'b1 : 1'b0;
    edge_idx++;
    watch(1'b1);
    b = pdm_data;
    mic_clk = ~mic_clk;
    watch(1'b0);
  endtask

  task automatic do_reset(input bit lr, input logic [7:0] o);
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; pcm_valid = 1'b0;
    lr_sel = lr; osr = o; mic_clk = lr ? 1'b0 : 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; en = 1'b1;
    repeat (4) @(negedge clk);
    edge_idx = 0; uf_cnt = 0; first_uf = 0; n_viol = 0; pdm_prev = pdm_data;
  endtask

  task automatic push(input logic [SW-1:0] v);
    int t;
    t = 0;
    pcm_in = v; pcm_valid = 1'b1;
    while (!pcm_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("push_timeout", 1, 0);
    @(negedge clk);
    pcm_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit   b, b1, b2;
    int   ones, o1, o2, accepted;
    exp_t e;

    vecs[0] = '{16'h4000, 16'h0000, 1, 8'd255, 1'b1, 256, 192,   1, 0, 1, 257};
    vecs[1] = '{16'h7FFF, 16'h8000, 2, 8'd255, 1'b1, 256, 255, 256, 0, 0,   0};
    vecs[2] = '{16'h0000, 16'h0000, 1, 8'd3,   1'b1,   4,   2,   4, 2, 1,   5};
    vecs[3] = '{16'h0000, 16'h0000, 1, 8'd3,   1'b0,   4,   2,   4, 2, 1,   5};
    vecs[4] = '{16'h4000, 16'h0000, 1, 8'd3,   1'b0,   4,   3,   4, 3, 1,   5};
    vecs[5] = '{16'hC000, 16'h0000, 1, 8'd7,   1'b1,   8,   2,   8, 2, 1,   9};
    vecs[6] = '{16'h7FFF, 16'h0000, 2, 8'd0,   1'b1,   2,   1,   2, 1, 2,   3};

    // Asynchronous reset before any clk edge.
    #1 rst_n = 1'b0;
    #2;
    check("rst_pdm",   pdm_data,  0);
    check("rst_level", level,     0);
    check("rst_ready", pcm_ready, 1);
    check("rst_uf",    underflow, 0);

    foreach (vecs[i]) begin
      do_reset(vecs[i].lr, vecs[i].osr);
      push(vecs[i].s0);
      if (vecs[i].nsamp > 1) push(vecs[i].s1);
      sbq.push_back('{vecs[i].ones1, vecs[i].ones2, vecs[i].ufc, vecs[i].uff});
      ones = 0;
      repeat (vecs[i].w1) begin mic_cycle(b); ones += int'(b); end
      o1 = ones;
      ones = 0;
      repeat (vecs[i].w2) begin mic_cycle(b); ones += int'(b); end
      o2 = ones;
      e = sbq.pop_front();
      check($sformatf("v%0d_ones1", i),    o1,       e.ones1);
      check($sformatf("v%0d_ones2", i),    o2,       e.ones2);
      check($sformatf("v%0d_uf_count", i), uf_cnt,   e.ufc);
      check($sformatf("v%0d_uf_edge", i),  first_uf, e.uff);
      check($sformatf("v%0d_edge_timing", i), n_viol, 0);
    end

    // Reset in the middle of a stream.
    do_reset(1'b1, 8'd255);
    push(16'h7FFF); push(16'h7FFF); push(16'h7FFF);
    mic_cycle(b); mic_cycle(b);
    check("mid_pdm_before",   pdm_data, 1);
    check("mid_level_before", level,    2);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_pdm",   pdm_data,  0);
    check("mid_rst_level", level,     0);
    check("mid_rst_ready", pcm_ready, 1);
    @(negedge clk); rst_n = 1'b1;

    // Backpressure with osr=0.
    do_reset(1'b1, 8'd0);
    accepted = 0;
    pcm_in = 16'h1234; pcm_valid = 1'b1;
    repeat (8) begin
      if (pcm_ready) accepted++;
      @(negedge clk);
    end
    pcm_valid = 1'b0;
    check("bp_accepted", accepted,  4);
    check("bp_level",    level,     4);
    check("bp_ready",    pcm_ready, 0);
    mic_clk = 1'b1;
    repeat (2) @(negedge clk);
    check("bp_level_pre_pop", level,     4);
    check("bp_ready_pre_pop", pcm_ready, 0);
    @(negedge clk);
    check("bp_level_post_pop", level,     3);
    check("bp_ready_post_pop", pcm_ready, 1);
    repeat (HALF - 3) @(negedge clk);
    mic_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    uf_cnt = 0;
    repeat (3) mic_cycle(b);
    check("bp_drained", level,  0);
    check("bp_no_uf",   uf_cnt, 0);
    mic_cycle(b);
    check("bp_uf_after_drain", uf_cnt, 1);

    // Disable and re-enable.
    do_reset(1'b1, 8'd255);
    push(16'h7FFF);
    repeat (3) mic_cycle(b);
    check("en_pdm_running", pdm_data, 1);
    en = 1'b0;
    repeat (2) @(negedge clk);
    check("en_off_pdm", pdm_data, 0);
    push(16'h0000);
    check("en_off_accepts", level, 1);
    ones = 0;
    repeat (2) begin mic_cycle(b); ones += int'(b); end
    check("en_off_ones",  ones,  0);
    check("en_off_level", level, 1);
    en = 1'b1;
    mic_cycle(b1);
    check("en_repop_level", level, 0);
    mic_cycle(b2);
    check("en_restart_b1", b1, 0);
    check("en_restart_b2", b2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pdm_mic_emulator.md
Name: pdm_mic_emulator

Overview:
- Synthesizable stand-in for the PDM microphone at the far end of the CIC front end.
- Accepts signed PCM samples over a valid/ready handshake and buffers them in a small FIFO.
- Converts each sample into a first-order delta-sigma 1-bit stream, clocked by the microphone clock that the CIC front end generates.
- Drives the bit on the edge that matches the channel-select convention, so it loops back into the CIC input for closed-loop test and calibration.

Parameters:
- SAMPLE_W, 16, PCM sample width (signed, two's complement).
- FIFO_DEPTH, 4, sample buffer depth; power of two, at least 2.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- mic_clk  in  1  microphone clock from the CIC block, about 1 MHz; asynchronous to clk in principle.
- lr_sel  in  1  1 = right channel: update on mic_clk rising edge. 0 = left channel: update on falling edge.
- en  in  1  modulator enable.
- osr  in  8  edges per sample = osr+1; matches the CIC dec_num.
- pcm_in  in  SAMPLE_W  signed PCM sample.
- pcm_valid  in  1  sample offered.
- pcm_ready  out  1  FIFO not full.
- pdm_data  out  1  PDM bit to the CIC data input.
- underflow  out  1  one-cycle pulse: a sample was needed but the FIFO was empty.
- level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO empty, level=0, pcm_ready=1.
  - pdm_data=0, underflow=0.
  - Accumulator = 0, hold counter = 0.
  - Current sample = 0 (signed), i.e. mid-scale.
  - Synchronizer flops = 0.
- Handshake:
  - A write occurs on a clk edge with pcm_valid && pcm_ready.
  - pcm_ready = (level != FIFO_DEPTH), registered from level; no combinational path from pcm_valid.
  - When full, pcm_in is ignored and no flag is raised.
- mic_clk handling:
  - Two-flop synchronizer, then a third flop for edge detect.
  - rise = s2 && !s3; fall = !s2 && s3.
  - Active edge = rise when lr_sel=1, fall when lr_sel=0; lr_sel is sampled on each clk.
- On an active edge with en=1, all updated on the next clk:
  - The hold counter selects the sample. If the counter is 0, pop the FIFO head into the current sample; the pop takes effect this same step.
  - If the FIFO is empty at that point, keep the previous sample and pulse underflow for one clk.
  - The counter then increments; it wraps to 0 after reaching osr.
  - Modulator, with x = current sample with MSB inverted (offset binary, SAMPLE_W bits): {carry, acc} = acc + x; pdm_data <= carry.
  - Ones density is exactly floor(n*x/2^SAMPLE_W) over n edges from acc=0.
- Latency: pdm_data changes 3 clk cycles after the mic_clk transition (2 sync + 1 register). This is about 60 ns, well inside the 520 ns half period, so the CIC samples a settled bit on the opposite edge.
- en=0:
  - No modulation; pdm_data=0.
  - Accumulator and hold counter cleared.
  - FIFO retains contents and still accepts writes.
  - On re-enable, the first active edge pops a new sample.
- Simultaneous push and pop in one clk: both happen and level is unchanged. Push when full+pop is refused, because ready is registered.
- osr changed mid-sample: takes effect at the next counter compare. If the counter is already above the new osr, it wraps at 8-bit overflow. This is documented, not protected.
- Reset mid-operation: all state returns to reset values immediately, and the FIFO contents are lost.

Decomposition:
- Shared package: SAMPLE_W default, the offset-binary conversion function, and a localparam for synchronizer depth (2).
- One sub-module: pdm_sample_fifo, a synchronous FIFO with push, pop, level, full and empty outputs, reused later by the capture path.
- The modulator, synchronizer and hold counter stay inline.

Test Plan:
- Reset then idle: rst_n low mid-stream → pdm_data=0, level=0, pcm_ready=1 immediately, with no clk edge needed.
- Density +0.5: push 0x4000, osr=255, lr_sel=1, en=1, mic_clk 1 MHz → exactly 192 ones in the first 256 rising edges; underflow pulses at edge 257. In the loopback with CIC comb_num=0, dec_num=255, the CIC outputs 192.
- Full scale: push 0x7FFF then 0x8000, osr=255 → 255 ones in the first 256 edges, then 0 ones in the next 256.
- Edge select: lr_sel=0 → pdm_data transitions only 3 clk after mic_clk falling edges; never within 3 clk after a rising edge.
- Backpressure: hold pcm_valid high with no mic_clk → 4 writes accepted, pcm_ready falls, level=4. Enable mic_clk with osr=0 → one pop per active edge and pcm_ready reasserts one clk after the first pop.
- Underflow/repeat: push one sample 0x0000, osr=3 → 8 edges give 4 ones; one underflow pulse at edge 5, and the density stays 50%.
